// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode/issue.
// Compacts fetch lanes on push, pops in program order, flushes in one cycle.
package tortoise_pkg;

  localparam int IFQ_DEPTH       = 8;
  localparam int INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } ex_t;

  typedef struct packed {
    logic        is_taken;
    logic [31:0] target;
  } predict_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    ex_t         ex;
    predict_t    predict;
  } fetch_entry_t;

endpackage

module fetch_queue
  import tortoise_pkg::*;
#(
  parameter int DEPTH      = IFQ_DEPTH,
  parameter int PUSH_WIDTH = INSTR_PER_FETCH,
  parameter int POP_WIDTH  = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  fetch_entry_t [PUSH_WIDTH-1:0]   fetch_i,
  output logic                            fetch_ready_o,
  output fetch_entry_t [POP_WIDTH-1:0]    instr_o,
  output logic [POP_WIDTH-1:0]            instr_valid_o,
  input  logic [POP_WIDTH-1:0]            instr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic                            empty_o,
  output logic                            full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  fetch_entry_t mem [DEPTH];

  ptr_t rd_ptr;
  ptr_t wr_ptr;
  cnt_t count;

  logic [PUSH_WIDTH-1:0] keep;
  int unsigned           lane_off [PUSH_WIDTH];
  cnt_t                  n_keep;
  logic                  any_valid;
  logic                  push_en;
  cnt_t                  n_push;
  cnt_t                  n_pop;

  // Modular pointer add; inc never exceeds DEPTH.
  function automatic ptr_t ptr_add(ptr_t p, int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return ptr_t'(s);
  endfunction

  // Keep valid lanes up to and including the first redirecting one.
  always_comb begin
    logic stop;
    stop      = 1'b0;
    keep      = '0;
    n_keep    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      lane_off[k] = 32'(n_keep);
      any_valid   = any_valid | fetch_i[k].valid;
      if (!stop && fetch_i[k].valid) begin
        keep[k] = 1'b1;
        n_keep  = n_keep + cnt_t'(1);
        if (fetch_i[k].ex.valid || fetch_i[k].predict.is_taken)
          stop = 1'b1;
      end
    end
  end

  assign fetch_ready_o = (cnt_t'(DEPTH) - count) >= cnt_t'(PUSH_WIDTH);
  assign push_en       = fetch_ready_o && any_valid;
  assign n_push        = push_en ? n_keep : '0;

  // Oldest entries presented from rd_ptr onward.
  always_comb begin
    for (int unsigned j = 0; j < POP_WIDTH; j++) begin
      instr_valid_o[j] = count > cnt_t'(j);
      instr_o[j]       = mem[ptr_add(rd_ptr, j)];
    end
  end

  // Pop only the contiguous acked prefix starting at lane 0.
  always_comb begin
    logic go;
    go    = 1'b1;
    n_pop = '0;
    for (int j = 0; j < POP_WIDTH; j++) begin
      if (go && instr_ack_i[j] && instr_valid_o[j])
        n_pop = n_pop + cnt_t'(1);
      else
        go = 1'b0;
    end
  end

  // Pointer and occupancy update; flush returns to the reset state.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= ptr_add(rd_ptr, 32'(n_pop));
      wr_ptr <= ptr_add(wr_ptr, 32'(n_push));
      count  <= count + n_push - n_pop;
    end
  end

  // Compacted write of the kept lanes.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_en) begin
      for (int k = 0; k < PUSH_WIDTH; k++) begin
        if (keep[k])
          mem[ptr_add(wr_ptr, lane_off[k])] <= fetch_i[k];
      end
    end
  end

  assign count_o = count;
  assign empty_o = count == '0;
  assign full_o  = count == cnt_t'(DEPTH);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed check of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;
  import tortoise_pkg::*;

  localparam int D  = 8;
  localparam int PW = 2;
  localparam int QW = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  flush_i = 1'b0;
  fetch_entry_t [PW-1:0] fetch_i = '0;
  logic                  fetch_ready_o;
  fetch_entry_t [QW-1:0] instr_o;
  logic [QW-1:0]         instr_valid_o;
  logic [QW-1:0]         instr_ack_i = '0;
  logic [3:0]            count_o;
  logic                  empty_o;
  logic                  full_o;

  fetch_queue #(
    .DEPTH(D), .PUSH_WIDTH(PW), .POP_WIDTH(QW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fetch_i(fetch_i), .fetch_ready_o(fetch_ready_o),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ack_i(instr_ack_i), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  fetch_entry_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit inited = 0;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [QW-1:0] therm(input int n);
    logic [QW-1:0] v;
    for (int j = 0; j < QW; j++) v[j] = j < n;
    return v;
  endfunction

  function automatic fetch_entry_t ent(input bit v, input bit exv,
                                       input bit tk);
    fetch_entry_t e;
    e.valid            = v;
    e.pc               = $urandom;
    e.instr            = $urandom;
    e.ex.valid         = exv;
    e.ex.cause         = 5'($urandom);
    e.predict.is_taken = tk;
    e.predict.target   = $urandom;
    return e;
  endfunction

  task automatic compare();
    int n;
    n = q.size();
    check("count", 128'(count_o), 128'(n));
    check("empty", 128'(empty_o), 128'(n == 0));
    check("full", 128'(full_o), 128'(n == D));
    check("ready", 128'(fetch_ready_o), 128'((D - n) >= PW));
    check("valid", 128'(instr_valid_o), 128'(therm(n)));
    for (int j = 0; j < QW; j++)
      if (j < n) check("data", 128'(instr_o[j]), 128'(q[j]));
  endtask

  task automatic cycle(input fetch_entry_t l0, input fetch_entry_t l1,
                       input logic [1:0] ack, input logic fl,
                       input logic rs);
    int  pre;
    bit  rdy;
    int  np;
    fetch_entry_t ln [2];
    pre = q.size();
    fetch_i = {l1, l0};
    instr_ack_i = ack;
    flush_i = fl;
    rst_i = rs;
    if (inited) begin
      #1;
      check("ready_pre", 128'(fetch_ready_o), 128'((D - pre) >= PW));
      check("valid_pre", 128'(instr_valid_o), 128'(therm(pre)));
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      rdy = (D - pre) >= PW;
      np = 0;
      for (int j = 0; j < QW; j++) begin
        if (ack[j] && j < pre) np++;
        else break;
      end
      repeat (np) void'(q.pop_front());
      ln[0] = l0;
      ln[1] = l1;
      if (rdy) begin
        for (int k = 0; k < PW; k++) begin
          if (ln[k].valid) begin
            q.push_back(ln[k]);
            if (ln[k].ex.valid || ln[k].predict.is_taken) break;
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
    inited = 1;
    compare();
  endtask

  fetch_entry_t nil, a, b, c, x, y;

  initial begin
    nil = '0;
    // 1: reset, push A,B
    cycle(nil, nil, 2'b00, 1'b0, 1'b1);
    a = ent(1, 0, 0);
    b = ent(1, 0, 0);
    cycle(a, b, 2'b00, 1'b0, 1'b0);
    check("t1_a", 128'(instr_o[0]), 128'(a));
    check("t1_b", 128'(instr_o[1]), 128'(b));
    check("t1_cnt", 128'(count_o), 128'(2));
    // 2: compaction
    cycle(nil, nil, 2'b00, 1'b0, 1'b1);
    c = ent(1, 0, 0);
    cycle(ent(0, 0, 0), c, 2'b00, 1'b0, 1'b0);
    check("t2_c", 128'(instr_o[0]), 128'(c));
    check("t2_cnt", 128'(count_o), 128'(1));
    // 3: redirect truncation
    cycle(nil, nil, 2'b00, 1'b0, 1'b1);
    x = ent(1, 0, 1);
    cycle(x, ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
    y = ent(1, 1, 0);
    cycle(y, ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
    check("t3_cnt", 128'(count_o), 128'(2));
    check("t3_d", 128'(instr_o[0]), 128'(x));
    check("t3_f", 128'(instr_o[1]), 128'(y));
    // 4: fill, hold while full, drain
    cycle(nil, nil, 2'b00, 1'b0, 1'b1);
    repeat (3) cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
    check("t4_rdy6", 128'(fetch_ready_o), 128'(1));
    cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
    check("t4_full", 128'(full_o), 128'(1));
    a = ent(1, 0, 0);
    b = ent(1, 0, 0);
    repeat (3) cycle(a, b, 2'b00, 1'b0, 1'b0);
    check("t4_hold", 128'(count_o), 128'(8));
    cycle(a, b, 2'b11, 1'b0, 1'b0);
    check("t4_pop", 128'(count_o), 128'(6));
    cycle(a, b, 2'b00, 1'b0, 1'b0);
    check("t4_acc", 128'(count_o), 128'(8));
    // 5: steady-state wrap
    cycle(nil, nil, 2'b00, 1'b0, 1'b1);
    repeat (3) cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
    repeat (20) cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b11, 1'b0, 1'b0);
    check("t5_cnt", 128'(count_o), 128'(6));
    cycle(nil, nil, 2'b10, 1'b0, 1'b0);
    check("t5_nopop", 128'(count_o), 128'(6));
    // 6: flush then reset at count 5
    for (int r = 0; r < 2; r++) begin
      cycle(nil, nil, 2'b00, 1'b0, 1'b1);
      repeat (2) cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b00, 1'b0, 1'b0);
      cycle(ent(1, 0, 0), nil, 2'b00, 1'b0, 1'b0);
      check("t6_five", 128'(count_o), 128'(5));
      cycle(ent(1, 0, 0), ent(1, 0, 0), 2'b11, r == 0, r == 1);
      check("t6_cnt", 128'(count_o), 128'(0));
      check("t6_empty", 128'(empty_o), 128'(1));
      check("t6_rdy", 128'(fetch_ready_o), 128'(1));
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(ent($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0),
            ent($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0),
            2'($urandom),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch queue between the fetch stage and decode/issue.
- Stores fetch_entry_t records from tortoise_pkg.
- Accepts up to PUSH_WIDTH entries per cycle with lane compaction and drops lanes after a redirect.
- Delivers up to POP_WIDTH entries per cycle in program order; supports a single-cycle flush.

Parameters:
DEPTH, tortoise_pkg::IFQ_DEPTH, number of entry slots; any integer >= PUSH_WIDTH and >= 2 (not restricted to powers of two).
PUSH_WIDTH, tortoise_pkg::INSTR_PER_FETCH, fetch lanes written per cycle (1..4).
POP_WIDTH, 1, issue lanes read per cycle (1..2).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  discard all stored entries (mispredict/exception redirect)
fetch_i  in  PUSH_WIDTH x $bits(fetch_entry_t)  fetch lanes; lane k is present when fetch_i[k].valid
fetch_ready_o  out  1  queue can accept a full PUSH_WIDTH bundle this cycle
instr_o  out  POP_WIDTH x $bits(fetch_entry_t)  oldest entries; lane 0 is oldest
instr_valid_o  out  POP_WIDTH  lane j holds a stored entry
instr_ack_i  in  POP_WIDTH  consumer takes lane j
count_o  out  $clog2(DEPTH+1)  stored entry count
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH

Behaviour:
- State:
  - memory of DEPTH entries;
  - rd_ptr and wr_ptr, each 0..DEPTH-1, wrapping explicitly (DEPTH-1 -> 0);
  - count, 0..DEPTH.
- Reset: rd_ptr = wr_ptr = count = 0.
  - All instr_valid_o = 0, empty_o = 1, full_o = 0, count_o = 0.
  - fetch_ready_o = 1. Memory contents are don't-care.
- fetch_ready_o = (DEPTH - count) >= PUSH_WIDTH.
  - Uses the registered count only; same-cycle pops are not credited.
  - Purely combinational from state; must not depend on fetch_i or instr_ack_i.
- Push accept: when fetch_ready_o = 1 and at least one lane valid.
  - The fetch stage must hold the bundle while fetch_ready_o = 0.
  - A bundle presented while fetch_ready_o = 0 is ignored, and nothing is written.
- Lane filtering, in lane order 0..PUSH_WIDTH-1:
  - Lanes with valid = 0 are skipped.
  - A kept lane whose ex.valid = 1, or whose predict.is_taken = 1, terminates the bundle.
  - All higher lanes are dropped, even if valid.
- Compaction: kept lanes are written to consecutive slots wr_ptr, wr_ptr+1, ... (mod DEPTH) in lane order.
  - wr_ptr advances by the number kept (n_push).
- Output: instr_o[j] = mem[(rd_ptr + j) mod DEPTH]; instr_valid_o[j] = (j < count).
  - instr_o is don't-care when not valid.
  - No bypass: a pushed entry appears on instr_o at the earliest one cycle after the push edge.
- Pop: n_pop = number of leading ones in (instr_ack_i & instr_valid_o).
  - Only the contiguous prefix from lane 0 counts; an ack on lane 1 without lane 0 pops nothing.
  - rd_ptr advances by n_pop (mod DEPTH).
- Same-cycle push and pop: count_next = count + n_push - n_pop.
  - Legal in every state, including full (no push accepted) and empty (no pop possible).
  - count never exceeds DEPTH.
- Flush: when flush_i = 1, next state equals the reset state.
  - Same-cycle push and pop are discarded.
  - flush_i has priority over everything except rst_i.
- Reset mid-operation behaves identically to flush; rst_i dominates.
- Assertions for the bench:
  - count <= DEPTH;
  - count == (wr_ptr - rd_ptr) mod DEPTH, with the full/empty ambiguity resolved by count;
  - instr_valid_o is a thermometer code.

Test Plan:
(All with DEPTH=8, PUSH_WIDTH=2, POP_WIDTH=2.)
1. Reset, then push {A,B} with no acks -> next cycle count_o=2, instr_o[0]=A, instr_o[1]=B, instr_valid_o=2'b11; A visible no earlier than one cycle after its push.
2. Push lanes {valid=0, C} -> C is stored in slot 0 (compaction); count_o=1.
3. Push {D with predict.is_taken=1, E} -> only D is stored. Push {F with ex.valid=1, G} -> only F is stored.
4. Fill to count=6 -> fetch_ready_o=1 (free=2); push 2 -> count=8, full_o=1, fetch_ready_o=0. A bundle held 3 cycles is not written. Then ack 2'b11 -> count=6, and the push is accepted the next cycle.
5. Wrap-around: 20 cycles of push-2 / ack-2 at steady state -> order preserved across the 7->0 pointer wrap; count constant. Ack 2'b10 -> no pop.
6. count=5, with push and ack asserted together with flush_i=1 -> next cycle count_o=0, empty_o=1, instr_valid_o=0, fetch_ready_o=1. Repeat with rst_i -> identical.
